// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton run sequencer.
//   - Run status encodings reported to the host.
//   - Sequencer FSM state type.
//   - Helper giving the rule-slot index width for a given table size.
package ca_pkg;

  localparam logic [1:0] ST_LIMIT = 2'b00;
  localparam logic [1:0] ST_FIXPT = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFinish
  } fsm_state_e;

  // A one-slot table still needs a 1-bit index.
  function automatic int unsigned slot_width(input int unsigned num_rules);
    return (num_rules > 1) ? $clog2(num_rules) : 1;
  endfunction

endpackage

// File: rtl/ca_rule_scheduler.sv
// Rule-table scheduler: walks the captured rule table, holding each slot for a
// programmable number of generations and wrapping after the active slot count.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_restart      go back to slot 0 and present its rule
//   i_advance      one generation was stepped
//   i_rules        captured rule table, slot k = i_rules[8k+7:8k]
//   i_num_rules    active slot count, already clamped to 1..NumRules
//   i_hold         generations per slot, already clamped to >= 1
//   o_rule         registered current rule
module ca_rule_scheduler import ca_pkg::*; #(
  parameter int unsigned NumRules   = 4,
  parameter int unsigned CountWidth = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_restart,
  input  logic                        i_advance,
  input  logic [NumRules*8-1:0]       i_rules,
  input  logic [$clog2(NumRules):0]   i_num_rules,
  input  logic [CountWidth-1:0]       i_hold,
  output logic [7:0]                  o_rule
);

  localparam int unsigned SlotW = slot_width(NumRules);

  logic [SlotW-1:0]      r_slot;
  logic [CountWidth-1:0] r_hold_cnt;
  logic [7:0]            r_rule;
  logic [SlotW-1:0]      w_slot_next;
  logic                  w_wrap;
  logic [31:0]           w_slot_inc;
  logic [7:0]            w_table [NumRules];

  for (genvar k = 0; k < NumRules; k++) begin : g_table
    assign w_table[k] = i_rules[8*k +: 8];
  end

  always_comb begin
    w_wrap      = (r_hold_cnt == (i_hold - CountWidth'(1)));
    w_slot_inc  = 32'(r_slot) + 32'd1;
    w_slot_next = (w_slot_inc >= 32'(i_num_rules)) ? '0 : SlotW'(w_slot_inc);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot     <= '0;
      r_hold_cnt <= '0;
      r_rule     <= '0;
    end else if (i_restart) begin
      r_slot     <= '0;
      r_hold_cnt <= '0;
      r_rule     <= w_table[0];
    end else if (i_advance) begin
      if (w_wrap) begin
        // Rule changes exactly on the boundary into the next generation.
        r_hold_cnt <= '0;
        r_slot     <= w_slot_next;
        r_rule     <= w_table[w_slot_next];
      end else begin
        r_hold_cnt <= r_hold_cnt + CountWidth'(1);
      end
    end
  end

  assign o_rule = r_rule;

endmodule

// File: rtl/ca_run_sequencer.sv
// Run sequencer for a dynamic-rule binary cellular automaton. Loads a seed,
// steps the automaton with a rotating rule table and stops on generation
// limit, fixed point or host abort, reporting over start/busy/done.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_start, i_abort            host request / abort
//   i_seed, i_rules             seed and rule table, captured on start
//   i_num_rules, i_hold         active slots and generations per slot
//   i_max_gens, i_fp_en         generation limit, fixed-point stop enable
//   o_busy, o_done, o_status    handshake and run outcome
//   o_gens_run, o_result        generations stepped and final state
//   o_ca_load, o_ca_set         automaton load pulse and seed
//   o_ca_ce, o_ca_rule          automaton step enable and rule
//   i_ca_state                  automaton current state
module ca_run_sequencer import ca_pkg::*; #(
  parameter int unsigned Width      = 16,
  parameter int unsigned NumRules   = 4,
  parameter int unsigned CountWidth = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [Width-1:0]          i_seed,
  input  logic [NumRules*8-1:0]     i_rules,
  input  logic [$clog2(NumRules):0] i_num_rules,
  input  logic [CountWidth-1:0]     i_hold,
  input  logic [CountWidth-1:0]     i_max_gens,
  input  logic                      i_fp_en,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_status,
  output logic [CountWidth-1:0]     o_gens_run,
  output logic [Width-1:0]          o_result,
  output logic                      o_ca_load,
  output logic [Width-1:0]          o_ca_set,
  output logic                      o_ca_ce,
  output logic [7:0]                o_ca_rule,
  input  logic [Width-1:0]          i_ca_state
);

  localparam int unsigned NumW = $clog2(NumRules) + 1;

  fsm_state_e            r_state, w_state_next;
  logic                  r_busy, r_done, r_ca_load, r_ca_ce, r_fp_en;
  logic [1:0]            r_status, w_stop_status;
  logic [CountWidth-1:0] r_gens_run, r_gen_cnt, r_hold, r_max_gens, w_gen_inc, w_hold_eff;
  logic [Width-1:0]      r_result, r_ca_set, r_prev_state;
  logic [NumRules*8-1:0] r_rules;
  logic [NumW-1:0]       r_num_rules, w_num_rules_eff;
  logic                  w_stop, w_sched_restart, w_sched_advance;

  assign w_num_rules_eff = (i_num_rules == '0 || 32'(i_num_rules) > NumRules) ?
                           NumW'(NumRules) : i_num_rules;
  assign w_hold_eff      = (i_hold == '0) ? CountWidth'(1) : i_hold;

  always_comb begin
    w_state_next    = r_state;
    w_stop          = 1'b0;
    w_stop_status   = ST_LIMIT;
    w_sched_restart = 1'b0;
    w_sched_advance = 1'b0;
    w_gen_inc       = (r_gen_cnt == '1) ? r_gen_cnt : r_gen_cnt + CountWidth'(1);
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StLoad;
      end
      StLoad: begin
        w_sched_restart = 1'b1;
        if (i_abort) begin
          w_stop        = 1'b1;
          w_stop_status = ST_ABORT;
        end else if (r_max_gens == '0) begin
          w_stop = 1'b1;
        end
        w_state_next = w_stop ? StFinish : StRun;
      end
      StRun: begin
        // Limit is tested on the incremented count so ca_ce drops together
        // with the last generation and gen_cnt never exceeds max_gens.
        if (i_abort) begin
          w_stop        = 1'b1;
          w_stop_status = ST_ABORT;
        end else if (r_fp_en && r_gen_cnt != '0 && i_ca_state == r_prev_state) begin
          w_stop        = 1'b1;
          w_stop_status = ST_FIXPT;
        end else if (w_gen_inc == r_max_gens) begin
          w_stop = 1'b1;
        end
        if (w_stop) w_state_next = StFinish;
        else        w_sched_advance = 1'b1;
      end
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= ST_LIMIT;
      r_gens_run   <= '0;
      r_result     <= '0;
      r_ca_load    <= 1'b0;
      r_ca_set     <= '0;
      r_ca_ce      <= 1'b0;
      r_fp_en      <= 1'b0;
      r_rules      <= '0;
      r_num_rules  <= '0;
      r_hold       <= '0;
      r_max_gens   <= '0;
      r_gen_cnt    <= '0;
      r_prev_state <= '0;
    end else begin
      r_state   <= w_state_next;
      r_done    <= 1'b0;
      r_ca_load <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_busy       <= 1'b1;
            r_ca_load    <= 1'b1;
            r_ca_set     <= i_seed;
            r_rules      <= i_rules;
            r_num_rules  <= w_num_rules_eff;
            r_hold       <= w_hold_eff;
            r_max_gens   <= i_max_gens;
            r_fp_en      <= i_fp_en;
            r_gen_cnt    <= '0;
            r_prev_state <= '0;
            r_status     <= ST_LIMIT;
          end
        end
        StLoad: begin
          r_gen_cnt <= '0;
          if (w_stop) r_status <= w_stop_status;
          else        r_ca_ce  <= 1'b1;
        end
        StRun: begin
          r_prev_state <= i_ca_state;
          if (w_stop) begin
            r_ca_ce  <= 1'b0;
            r_status <= w_stop_status;
            // Only the limit stop counts the generation stepped this cycle.
            if (w_stop_status == ST_LIMIT) r_gen_cnt <= w_gen_inc;
          end else begin
            r_gen_cnt <= w_gen_inc;
          end
        end
        StFinish: begin
          r_result   <= i_ca_state;
          r_gens_run <= r_gen_cnt;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ca_rule_scheduler #(
    .NumRules   (NumRules),
    .CountWidth (CountWidth)
  ) u_sched (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_restart   (w_sched_restart),
    .i_advance   (w_sched_advance),
    .i_rules     (r_rules),
    .i_num_rules (r_num_rules),
    .i_hold      (r_hold),
    .o_rule      (o_ca_rule)
  );

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_status   = r_status;
  assign o_gens_run = r_gens_run;
  assign o_result   = r_result;
  assign o_ca_load  = r_ca_load;
  assign o_ca_set   = r_ca_set;
  assign o_ca_ce    = r_ca_ce;

endmodule
